// File: rtl/io_map_pkg.sv
// Shared address map, board sizing and debounce state encoding for the data-side I/O bridge.
package io_map_pkg;

  localparam logic [31:0] DRAM_BASE = 32'h0000_4000;
  localparam int unsigned DRAM_AW   = 14;
  localparam logic [31:0] IO_BASE   = 32'hFFFF_F000;

  localparam logic [11:0] SEG_OFF = 12'h000;
  localparam logic [11:0] CNT_OFF = 12'h020;
  localparam logic [11:0] LED_OFF = 12'h060;
  localparam logic [11:0] SW_OFF  = 12'h070;
  localparam logic [11:0] BTN_OFF = 12'h078;

  localparam int unsigned DEB_CYCLES = 200000;
  localparam int unsigned SW_W       = 24;
  localparam int unsigned BTN_W      = 5;
  localparam int unsigned LED_W      = 24;

  typedef enum logic {
    STABLE,
    COUNTING
  } deb_state_e;

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser followed by a stable-count debounce FSM.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = io_map_pkg::DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb
);
  import io_map_pkg::*;

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  // Update on the edge where the count would reach DEB_CYCLES.
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  deb_state_e    state;
  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= STABLE;
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      deb   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      case (state)
        STABLE: begin
          if (sync2 != deb) begin
            state <= COUNTING;
            cnt   <= CW'(1);
          end else begin
            cnt <= '0;
          end
        end
        COUNTING: begin
          if (sync2 == deb) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt >= LAST) begin
            deb   <= sync2;
            state <= STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/io_bridge.sv
// Data-port address decoder: DRAM window rebasing plus the memory-mapped
// SEG/CNT/LED/SW/BTN register page, with a sticky flag for unmapped accesses.
module io_bridge #(
  parameter logic [31:0] DRAM_BASE  = io_map_pkg::DRAM_BASE,
  parameter int unsigned DRAM_AW    = io_map_pkg::DRAM_AW,
  parameter logic [31:0] IO_BASE    = io_map_pkg::IO_BASE,
  parameter int unsigned DEB_CYCLES = io_map_pkg::DEB_CYCLES,
  parameter int unsigned SW_W       = io_map_pkg::SW_W,
  parameter int unsigned BTN_W      = io_map_pkg::BTN_W,
  parameter int unsigned LED_W      = io_map_pkg::LED_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        cpu_addr,
  input  logic               cpu_we,
  input  logic [31:0]        cpu_wd,
  output logic [31:0]        cpu_rd,
  output logic               dram_we,
  output logic [DRAM_AW-1:0] dram_a,
  output logic [31:0]        dram_wd,
  input  logic [31:0]        dram_rd,
  input  logic [SW_W-1:0]    sw_i,
  input  logic [BTN_W-1:0]   btn_i,
  output logic [31:0]        seg_data,
  output logic [LED_W-1:0]   led_o,
  output logic               bus_err
);
  import io_map_pkg::*;

  // Exclusive upper bound of the DRAM window, one bit wider to avoid wrap.
  localparam logic [32:0] DRAM_END = {1'b0, DRAM_BASE} + (33'd1 << (DRAM_AW + 2));

  logic [31:0]      word_addr;
  logic [31:0]      dram_off;
  logic [11:0]      io_off;
  logic             dram_hit;
  logic             io_page;
  logic             sel_seg;
  logic             sel_cnt;
  logic             sel_led;
  logic             sel_sw;
  logic             sel_btn;
  logic             reg_hit;
  logic             unmapped;
  logic [31:0]      cnt;
  logic [SW_W-1:0]  sw_s1;
  logic [SW_W-1:0]  sw_s2;
  logic [BTN_W-1:0] btn_deb;
  logic             unused_bits;

  assign word_addr   = {cpu_addr[31:2], 2'b00};
  assign dram_off    = word_addr - DRAM_BASE;
  assign io_off      = word_addr[11:0];
  assign unused_bits = ^{cpu_addr[1:0], dram_off[31:DRAM_AW+2], dram_off[1:0]};

  // Address decode and the single-cycle load path.
  always_comb begin
    dram_hit = ({1'b0, word_addr} >= {1'b0, DRAM_BASE}) && ({1'b0, word_addr} < DRAM_END);
    io_page  = (word_addr[31:12] == IO_BASE[31:12]);
    sel_seg  = io_page && (io_off == SEG_OFF);
    sel_cnt  = io_page && (io_off == CNT_OFF);
    sel_led  = io_page && (io_off == LED_OFF);
    sel_sw   = io_page && (io_off == SW_OFF);
    sel_btn  = io_page && (io_off == BTN_OFF);
    reg_hit  = sel_seg || sel_cnt || sel_led || sel_sw || sel_btn;
    // Plain loads outside both windows are tolerated; stores and I/O-page misses are not.
    unmapped = (io_page && !reg_hit) || (cpu_we && !dram_hit && !io_page);

    dram_we = cpu_we && dram_hit;
    dram_a  = dram_off[DRAM_AW+1:2];
    dram_wd = cpu_wd;

    cpu_rd = 32'd0;
    if (dram_hit)     cpu_rd = dram_rd;
    else if (sel_seg) cpu_rd = seg_data;
    else if (sel_cnt) cpu_rd = cnt;
    else if (sel_led) cpu_rd = 32'(led_o);
    else if (sel_sw)  cpu_rd = 32'(sw_s2);
    else if (sel_btn) cpu_rd = 32'(btn_deb);
  end

  // Peripheral registers, cycle counter and switch synchroniser.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_data <= 32'd0;
      led_o    <= '0;
      bus_err  <= 1'b0;
      cnt      <= 32'd0;
      sw_s1    <= '0;
      sw_s2    <= '0;
    end else begin
      if (cpu_we && sel_seg) seg_data <= cpu_wd;
      if (cpu_we && sel_led) led_o <= cpu_wd[LED_W-1:0];
      cnt   <= (cpu_we && sel_cnt) ? 32'd0 : cnt + 32'd1;
      sw_s1 <= sw_i;
      sw_s2 <= sw_s1;
      if (unmapped) bus_err <= 1'b1;
    end
  end

  for (genvar i = 0; i < BTN_W; i++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn_i[i]),
      .deb  (btn_deb[i])
    );
  end

endmodule

// File: tb/tb_io_bridge.sv
// Scoreboard bench for io_bridge with a short debounce window.
module tb_io_bridge;

  localparam int unsigned DRAM_AW = 14;
  localparam int unsigned SW_W    = 24;
  localparam int unsigned BTN_W   = 5;
  localparam int unsigned LED_W   = 24;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [31:0]        cpu_addr;
  logic               cpu_we;
  logic [31:0]        cpu_wd;
  logic [31:0]        cpu_rd;
  logic               dram_we;
  logic [DRAM_AW-1:0] dram_a;
  logic [31:0]        dram_wd;
  logic [31:0]        dram_rd;
  logic [SW_W-1:0]    sw_i;
  logic [BTN_W-1:0]   btn_i;
  logic [31:0]        seg_data;
  logic [LED_W-1:0]   led_o;
  logic               bus_err;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  io_bridge #(
    .DEB_CYCLES(8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cpu_addr(cpu_addr),
    .cpu_we  (cpu_we),
    .cpu_wd  (cpu_wd),
    .cpu_rd  (cpu_rd),
    .dram_we (dram_we),
    .dram_a  (dram_a),
    .dram_wd (dram_wd),
    .dram_rd (dram_rd),
    .sw_i    (sw_i),
    .btn_i   (btn_i),
    .seg_data(seg_data),
    .led_o   (led_o),
    .bus_err (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic observe(input logic [31:0] got);
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      check(tag_q.pop_front(), got, exp_q.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    cpu_addr = 32'd0;
    cpu_we   = 1'b0;
    cpu_wd   = 32'd0;
    dram_rd  = 32'd0;
    sw_i     = '0;
    btn_i    = '0;
    tick();
    tick();

    // Reset state
    expect_val("rst_seg", 32'd0);  observe(seg_data);
    expect_val("rst_led", 32'd0);  observe(32'(led_o));
    expect_val("rst_err", 32'd0);  observe(32'(bus_err));
    cpu_addr = 32'hFFFF_F020;
    rst_n    = 1'b1;
    expect_val("rst_cnt", 32'd0);
    #1 observe(cpu_rd);

    // Free-running counter and write-to-clear
    expect_val("cnt_100", 32'd100);
    repeat (100) tick();
    #1 observe(cpu_rd);
    cpu_we = 1'b1;
    cpu_wd = 32'h0000_0055;
    expect_val("cnt_old_on_wr", 32'd100);
    #1 observe(cpu_rd);
    tick();
    cpu_we = 1'b0;
    expect_val("cnt_cleared", 32'd0);
    #1 observe(cpu_rd);
    expect_val("cnt_after_clr", 32'd1);
    tick();
    observe(cpu_rd);

    // SEG store and readback
    cpu_addr = 32'hFFFF_F000;
    cpu_we   = 1'b1;
    cpu_wd   = 32'h2500_0018;
    expect_val("seg_old_rd", 32'd0);
    #1 observe(cpu_rd);
    tick();
    cpu_we = 1'b0;
    expect_val("seg_data", 32'h2500_0018);
    expect_val("seg_rd", 32'h2500_0018);
    expect_val("seg_err", 32'd0);
    #1 observe(seg_data);
    observe(cpu_rd);
    observe(32'(bus_err));

    // DRAM window
    cpu_addr = 32'h0000_4008;
    cpu_we   = 1'b1;
    cpu_wd   = 32'hDEAD_BEEF;
    expect_val("dram_we", 32'd1);
    expect_val("dram_a", 32'd2);
    expect_val("dram_wd", 32'hDEAD_BEEF);
    #1 observe(32'(dram_we));
    observe(32'(dram_a));
    observe(dram_wd);
    tick();
    cpu_we  = 1'b0;
    dram_rd = 32'h0000_1234;
    expect_val("dram_rd", 32'h0000_1234);
    #1 observe(cpu_rd);
    cpu_addr = 32'h0000_3FFC;
    expect_val("dram_below", 32'd0);
    #1 observe(cpu_rd);
    cpu_addr = 32'h0001_3FFC;
    expect_val("dram_top_rd", 32'h0000_1234);
    expect_val("dram_top_a", 32'h0000_3FFF);
    #1 observe(cpu_rd);
    observe(32'(dram_a));
    cpu_addr = 32'h0001_4000;
    expect_val("dram_above", 32'd0);
    #1 observe(cpu_rd);
    cpu_addr = 32'h0000_400B;
    expect_val("dram_byte_a", 32'd2);
    #1 observe(32'(dram_a));

    // Switch synchroniser
    cpu_addr = 32'hFFFF_F070;
    sw_i     = 24'hA5A5A5;
    expect_val("sw_1edge", 32'd0);
    expect_val("sw_2edge", 32'h00A5_A5A5);
    tick();
    observe(cpu_rd);
    tick();
    observe(cpu_rd);

    // LED store, upper bits dropped
    cpu_addr = 32'hFFFF_F060;
    cpu_we   = 1'b1;
    cpu_wd   = 32'hFFFF_FFFF;
    expect_val("led_o", 32'h00FF_FFFF);
    expect_val("led_rd", 32'h00FF_FFFF);
    tick();
    cpu_we = 1'b0;
    #1 observe(32'(led_o));
    observe(cpu_rd);

    // Store to RO switch register is ignored and not an error
    cpu_addr = 32'hFFFF_F070;
    cpu_we   = 1'b1;
    cpu_wd   = 32'd0;
    expect_val("sw_ro_rd", 32'h00A5_A5A5);
    expect_val("sw_ro_err", 32'd0);
    tick();
    cpu_we = 1'b0;
    #1 observe(cpu_rd);
    observe(32'(bus_err));

    // Plain load outside windows is harmless
    cpu_addr = 32'h0000_0000;
    expect_val("ld0_rd", 32'd0);
    expect_val("ld0_err", 32'd0);
    #1 observe(cpu_rd);
    tick();
    observe(32'(bus_err));

    // I/O page miss on a load sets the sticky flag
    cpu_addr = 32'hFFFF_F040;
    expect_val("iomiss_rd", 32'd0);
    expect_val("iomiss_err", 32'd1);
    #1 observe(cpu_rd);
    tick();
    cpu_addr = 32'h0000_0000;
    observe(32'(bus_err));

    // Reset wins over a same-cycle SEG store and clears bus_err
    rst_n    = 1'b0;
    cpu_addr = 32'hFFFF_F000;
    cpu_we   = 1'b1;
    cpu_wd   = 32'h1234_5678;
    expect_val("rstwr_seg", 32'd0);
    expect_val("rstwr_err", 32'd0);
    expect_val("rstwr_led", 32'd0);
    tick();
    rst_n  = 1'b1;
    cpu_we = 1'b0;
    observe(seg_data);
    observe(32'(bus_err));
    observe(32'(led_o));

    // Unmapped store
    cpu_addr = 32'h0000_1000;
    cpu_we   = 1'b1;
    cpu_wd   = 32'h0BAD_0BAD;
    expect_val("unmap_dram_we", 32'd0);
    expect_val("unmap_err", 32'd1);
    #1 observe(32'(dram_we));
    tick();
    cpu_we = 1'b0;
    observe(32'(bus_err));

    // Button debounce: a short glitch is rejected, a held press lands after 10 edges
    cpu_addr = 32'hFFFF_F078;
    repeat (3) tick();
    btn_i[0] = 1'b1;
    expect_val("btn_glitch", 32'd0);
    repeat (5) tick();
    btn_i[0] = 1'b0;
    repeat (20) tick();
    observe(cpu_rd);
    btn_i[0] = 1'b1;
    expect_val("btn_9edges", 32'd0);
    expect_val("btn_10edges", 32'd1);
    repeat (9) tick();
    observe(cpu_rd);
    tick();
    observe(cpu_rd);
    btn_i[0] = 1'b0;
    expect_val("btn_rel_9", 32'd1);
    expect_val("btn_rel_10", 32'd0);
    repeat (9) tick();
    observe(cpu_rd);
    tick();
    observe(cpu_rd);

    check("sb_left", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
